// File: rtl/udatapath_seq_gen.sv
// -----------------------------------------------------------------------------
// udatapath_seq_gen
//
// Multi-cycle datapath: a register file (entry 0 reads as zero, entry IR_INDEX
// is the instruction register), three index muxes (IR field or control-unit
// value), and an ALU driven by a start/busy/done handshake. Shifts run
// iteratively, one bit per cycle. Writeback and flag capture are registered.
//
// Ports
//   uDATAPATH_CLOCK_50            clock, rising edge
//   uDATAPATH_RESET_InLow         asynchronous reset, active low
//   uDATAPATH_start_InHigh        operation request, sampled in IDLE only
//   uDATAPATH_aluselection_InBUS  operation code
//   uDATAPATH_setcc_InHigh        capture flags at writeback
//   uDATAPATH_wren_InHigh         write result to register C at writeback
//   uDATAPATH_BUS_SELECTOR_A/B/C  0 = IR field, 1 = control-unit index
//   uDATAPATH_BUS_CONTROL_A/B/C   control-unit register indices
//   uDATAPATH_clear_InHigh        synchronous clear of one register
//   uDATAPATH_clearsel_InBUS      register to clear
//   uDATAPATH_extwr_InHigh        external (memory/IO) write enable
//   uDATAPATH_extsel_InBUS        external write index
//   uDATAPATH_extdata_InBUS       external write data
//   uDATAPATH_BUS_A / _BUS_B      live reads of the selected registers
//   uDATAPATH_Registro_IR         live IR contents
//   uDATAPATH_data_OutBUS         last ALU result (registered)
//   uDATAPATH_psr_OutBUS          flags {N,Z,V,C} (registered)
//   uDATAPATH_busy_OutHigh        operation in progress
//   uDATAPATH_done_OutHigh        one-cycle pulse after writeback
// -----------------------------------------------------------------------------
module udatapath_seq_gen #(
    parameter int DATAWIDTH_BUS = 32,
    parameter int NUM_REGS      = 40,
    parameter int REGSEL_WIDTH  = 6,
    parameter int IR_INDEX      = 38,
    parameter int ALU_SEL_WIDTH = 4
) (
    input  logic                     uDATAPATH_CLOCK_50,
    input  logic                     uDATAPATH_RESET_InLow,
    input  logic                     uDATAPATH_start_InHigh,
    input  logic [ALU_SEL_WIDTH-1:0] uDATAPATH_aluselection_InBUS,
    input  logic                     uDATAPATH_setcc_InHigh,
    input  logic                     uDATAPATH_wren_InHigh,
    input  logic                     uDATAPATH_BUS_SELECTOR_A,
    input  logic                     uDATAPATH_BUS_SELECTOR_B,
    input  logic                     uDATAPATH_BUS_SELECTOR_C,
    input  logic [REGSEL_WIDTH-1:0]  uDATAPATH_BUS_CONTROL_A,
    input  logic [REGSEL_WIDTH-1:0]  uDATAPATH_BUS_CONTROL_B,
    input  logic [REGSEL_WIDTH-1:0]  uDATAPATH_BUS_CONTROL_C,
    input  logic                     uDATAPATH_clear_InHigh,
    input  logic [REGSEL_WIDTH-1:0]  uDATAPATH_clearsel_InBUS,
    input  logic                     uDATAPATH_extwr_InHigh,
    input  logic [REGSEL_WIDTH-1:0]  uDATAPATH_extsel_InBUS,
    input  logic [DATAWIDTH_BUS-1:0] uDATAPATH_extdata_InBUS,
    output logic [DATAWIDTH_BUS-1:0] uDATAPATH_BUS_A,
    output logic [DATAWIDTH_BUS-1:0] uDATAPATH_BUS_B,
    output logic [DATAWIDTH_BUS-1:0] uDATAPATH_Registro_IR,
    output logic [DATAWIDTH_BUS-1:0] uDATAPATH_data_OutBUS,
    output logic [3:0]               uDATAPATH_psr_OutBUS,
    output logic                     uDATAPATH_busy_OutHigh,
    output logic                     uDATAPATH_done_OutHigh
);

    localparam int MSB     = DATAWIDTH_BUS - 1;
    localparam int SHAMT_W = $clog2(DATAWIDTH_BUS);

    localparam logic [ALU_SEL_WIDTH-1:0] OP_ADD    = ALU_SEL_WIDTH'(0);
    localparam logic [ALU_SEL_WIDTH-1:0] OP_SUB    = ALU_SEL_WIDTH'(1);
    localparam logic [ALU_SEL_WIDTH-1:0] OP_AND    = ALU_SEL_WIDTH'(2);
    localparam logic [ALU_SEL_WIDTH-1:0] OP_OR     = ALU_SEL_WIDTH'(3);
    localparam logic [ALU_SEL_WIDTH-1:0] OP_XOR    = ALU_SEL_WIDTH'(4);
    localparam logic [ALU_SEL_WIDTH-1:0] OP_ANDN   = ALU_SEL_WIDTH'(5);
    localparam logic [ALU_SEL_WIDTH-1:0] OP_PASS_B = ALU_SEL_WIDTH'(7);
    localparam logic [ALU_SEL_WIDTH-1:0] OP_SLL    = ALU_SEL_WIDTH'(8);
    localparam logic [ALU_SEL_WIDTH-1:0] OP_SRL    = ALU_SEL_WIDTH'(9);
    localparam logic [ALU_SEL_WIDTH-1:0] OP_SRA    = ALU_SEL_WIDTH'(10);

    // One extra bit so the range test also works when NUM_REGS == 2**REGSEL_WIDTH.
    localparam logic [REGSEL_WIDTH:0] LP_NUM_REGS = (REGSEL_WIDTH + 1)'(NUM_REGS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_SHIFT
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [DATAWIDTH_BUS-1:0] r_regs      [NUM_REGS];
    logic [DATAWIDTH_BUS-1:0] w_regs_next [NUM_REGS];

    // Operands and control latched at start; r_a doubles as the shift work value.
    logic [DATAWIDTH_BUS-1:0] r_a;
    logic [DATAWIDTH_BUS-1:0] r_b;
    logic [ALU_SEL_WIDTH-1:0] r_op;
    logic [REGSEL_WIDTH-1:0]  r_c_idx;
    logic                     r_setcc;
    logic                     r_wren;
    logic [SHAMT_W-1:0]       r_count;
    logic                     r_shc;
    logic [DATAWIDTH_BUS-1:0] r_data;
    logic [3:0]               r_psr;
    logic                     r_done;

    logic [DATAWIDTH_BUS-1:0] w_ir;
    logic [REGSEL_WIDTH-1:0]  w_idx_a;
    logic [REGSEL_WIDTH-1:0]  w_idx_b;
    logic [REGSEL_WIDTH-1:0]  w_idx_c;
    logic [DATAWIDTH_BUS-1:0] w_bus_a;
    logic [DATAWIDTH_BUS-1:0] w_bus_b;
    logic                     w_start_shift;
    logic                     w_wb_en;
    logic [DATAWIDTH_BUS-1:0] w_shift_val;
    logic                     w_shift_bit;
    logic [DATAWIDTH_BUS:0]   w_add_ext;
    logic [DATAWIDTH_BUS:0]   w_sub_ext;
    logic [DATAWIDTH_BUS-1:0] w_result;
    logic                     w_flag_v;
    logic                     w_flag_c;

    // ---------------------------------------------------------------- reads
    assign w_ir = r_regs[IR_INDEX];

    assign w_idx_a = uDATAPATH_BUS_SELECTOR_A ? uDATAPATH_BUS_CONTROL_A : REGSEL_WIDTH'(w_ir[18:14]);
    assign w_idx_b = uDATAPATH_BUS_SELECTOR_B ? uDATAPATH_BUS_CONTROL_B : REGSEL_WIDTH'(w_ir[4:0]);
    assign w_idx_c = uDATAPATH_BUS_SELECTOR_C ? uDATAPATH_BUS_CONTROL_C : REGSEL_WIDTH'(w_ir[29:25]);

    // Indices past the end of the file read as zero; entry 0 is always zero.
    assign w_bus_a = ({1'b0, w_idx_a} < LP_NUM_REGS) ? r_regs[w_idx_a] : '0;
    assign w_bus_b = ({1'b0, w_idx_b} < LP_NUM_REGS) ? r_regs[w_idx_b] : '0;

    assign uDATAPATH_BUS_A        = w_bus_a;
    assign uDATAPATH_BUS_B        = w_bus_b;
    assign uDATAPATH_Registro_IR  = w_ir;
    assign uDATAPATH_data_OutBUS  = r_data;
    assign uDATAPATH_psr_OutBUS   = r_psr;
    assign uDATAPATH_busy_OutHigh = (r_state != ST_IDLE);
    assign uDATAPATH_done_OutHigh = r_done;

    // A zero shift amount skips SHIFT entirely and finishes like any other op.
    assign w_start_shift = ((uDATAPATH_aluselection_InBUS == OP_SLL) ||
                            (uDATAPATH_aluselection_InBUS == OP_SRL) ||
                            (uDATAPATH_aluselection_InBUS == OP_SRA)) &&
                           (w_bus_b[SHAMT_W-1:0] != '0);

    assign w_wb_en = (r_state == ST_EXEC) && r_wren;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge uDATAPATH_CLOCK_50 or negedge uDATAPATH_RESET_InLow) begin
        if (!uDATAPATH_RESET_InLow) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (uDATAPATH_start_InHigh) begin
                    w_state_next = w_start_shift ? ST_SHIFT : ST_EXEC;
                end
            end
            ST_SHIFT: begin
                if (r_count == SHAMT_W'(1)) begin
                    w_state_next = ST_EXEC;
                end
            end
            ST_EXEC: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- shifter
    always_comb begin
        w_shift_val = r_a;
        w_shift_bit = 1'b0;
        case (r_op)
            OP_SLL: begin
                w_shift_val = {r_a[MSB-1:0], 1'b0};
                w_shift_bit = r_a[MSB];
            end
            OP_SRL: begin
                w_shift_val = {1'b0, r_a[MSB:1]};
                w_shift_bit = r_a[0];
            end
            OP_SRA: begin
                w_shift_val = {r_a[MSB], r_a[MSB:1]};
                w_shift_bit = r_a[0];
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------- ALU
    assign w_add_ext = {1'b0, r_a} + {1'b0, r_b};
    // Top bit of the extended difference is the unsigned borrow.
    assign w_sub_ext = {1'b0, r_a} - {1'b0, r_b};

    always_comb begin
        w_result = r_a;
        w_flag_v = 1'b0;
        w_flag_c = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_result = w_add_ext[MSB:0];
                w_flag_c = w_add_ext[DATAWIDTH_BUS];
                w_flag_v = (r_a[MSB] == r_b[MSB]) && (w_add_ext[MSB] != r_a[MSB]);
            end
            OP_SUB: begin
                w_result = w_sub_ext[MSB:0];
                w_flag_c = w_sub_ext[DATAWIDTH_BUS];
                w_flag_v = (r_a[MSB] != r_b[MSB]) && (w_sub_ext[MSB] != r_a[MSB]);
            end
            OP_AND:    w_result = r_a & r_b;
            OP_OR:     w_result = r_a | r_b;
            OP_XOR:    w_result = r_a ^ r_b;
            OP_ANDN:   w_result = r_a & ~r_b;
            OP_PASS_B: w_result = r_b;
            OP_SLL, OP_SRL, OP_SRA: begin
                // Shifting already happened in r_a; carry is the last bit out.
                w_result = r_a;
                w_flag_c = r_shc;
            end
            default:   w_result = r_a;
        endcase
    end

    // ---------------------------------------------------------------- control / result registers
    always_ff @(posedge uDATAPATH_CLOCK_50 or negedge uDATAPATH_RESET_InLow) begin
        if (!uDATAPATH_RESET_InLow) begin
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_c_idx <= '0;
            r_setcc <= 1'b0;
            r_wren  <= 1'b0;
            r_count <= '0;
            r_shc   <= 1'b0;
            r_data  <= '0;
            r_psr   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (uDATAPATH_start_InHigh) begin
                        r_a     <= w_bus_a;
                        r_b     <= w_bus_b;
                        r_op    <= uDATAPATH_aluselection_InBUS;
                        r_c_idx <= w_idx_c;
                        r_setcc <= uDATAPATH_setcc_InHigh;
                        r_wren  <= uDATAPATH_wren_InHigh;
                        r_count <= w_bus_b[SHAMT_W-1:0];
                        r_shc   <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    r_a     <= w_shift_val;
                    r_shc   <= w_shift_bit;
                    r_count <= r_count - SHAMT_W'(1);
                end
                ST_EXEC: begin
                    r_data <= w_result;
                    if (r_setcc) begin
                        r_psr <= {w_result[MSB], (w_result == '0), w_flag_v, w_flag_c};
                    end
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------- register file
    // Per-entry write select: clear beats writeback beats external write.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign w_regs_next[gi] = '0;
            end else begin : g_entry
                localparam logic [REGSEL_WIDTH-1:0] LP_IDX = REGSEL_WIDTH'(gi);
                logic w_clr_hit;
                logic w_wb_hit;
                logic w_ext_hit;
                assign w_clr_hit = uDATAPATH_clear_InHigh && (uDATAPATH_clearsel_InBUS == LP_IDX);
                assign w_wb_hit  = w_wb_en && (r_c_idx == LP_IDX);
                assign w_ext_hit = uDATAPATH_extwr_InHigh && (uDATAPATH_extsel_InBUS == LP_IDX);
                assign w_regs_next[gi] = w_clr_hit ? '0 :
                                         w_wb_hit  ? w_result :
                                         w_ext_hit ? uDATAPATH_extdata_InBUS :
                                                     r_regs[gi];
            end
        end
    endgenerate

    always_ff @(posedge uDATAPATH_CLOCK_50 or negedge uDATAPATH_RESET_InLow) begin
        if (!uDATAPATH_RESET_InLow) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= w_regs_next[i];
            end
        end
    end

endmodule

// File: tb/tb_udatapath_seq_gen.sv
// -----------------------------------------------------------------------------
// tb_udatapath_seq_gen
//
// Directed scenarios followed by randomized operations, checked against a
// behavioural model of the register file and ALU kept in this bench.
// -----------------------------------------------------------------------------
module tb_udatapath_seq_gen;

    localparam int NR  = 40;
    localparam int IRI = 38;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start;
    logic [3:0]  op;
    logic        setcc, wren;
    logic        sel_a, sel_b, sel_c;
    logic [5:0]  ctl_a, ctl_b, ctl_c;
    logic        clr;
    logic [5:0]  clrsel;
    logic        extwr;
    logic [5:0]  extsel;
    logic [31:0] extdata;
    logic [31:0] bus_a, bus_b, ir_out, data_out;
    logic [3:0]  psr;
    logic        busy, done;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_regs [NR];
    logic [3:0]  m_psr;
    logic [31:0] m_data;

    always #5 clk = ~clk;

    udatapath_seq_gen dut (
        .uDATAPATH_CLOCK_50           (clk),
        .uDATAPATH_RESET_InLow        (rst_n),
        .uDATAPATH_start_InHigh       (start),
        .uDATAPATH_aluselection_InBUS (op),
        .uDATAPATH_setcc_InHigh       (setcc),
        .uDATAPATH_wren_InHigh        (wren),
        .uDATAPATH_BUS_SELECTOR_A     (sel_a),
        .uDATAPATH_BUS_SELECTOR_B     (sel_b),
        .uDATAPATH_BUS_SELECTOR_C     (sel_c),
        .uDATAPATH_BUS_CONTROL_A      (ctl_a),
        .uDATAPATH_BUS_CONTROL_B      (ctl_b),
        .uDATAPATH_BUS_CONTROL_C      (ctl_c),
        .uDATAPATH_clear_InHigh       (clr),
        .uDATAPATH_clearsel_InBUS     (clrsel),
        .uDATAPATH_extwr_InHigh       (extwr),
        .uDATAPATH_extsel_InBUS       (extsel),
        .uDATAPATH_extdata_InBUS      (extdata),
        .uDATAPATH_BUS_A              (bus_a),
        .uDATAPATH_BUS_B              (bus_b),
        .uDATAPATH_Registro_IR        (ir_out),
        .uDATAPATH_data_OutBUS        (data_out),
        .uDATAPATH_psr_OutBUS         (psr),
        .uDATAPATH_busy_OutHigh       (busy),
        .uDATAPATH_done_OutHigh       (done)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------ model
    function automatic logic [31:0] m_read(input int idx);
        if (idx <= 0 || idx >= NR) return 32'h0;
        return m_regs[idx];
    endfunction

    function automatic void m_write(input int idx, input logic [31:0] v);
        if (idx > 0 && idx < NR) m_regs[idx] = v;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = 32'h0;
        m_psr  = 4'h0;
        m_data = 32'h0;
    endfunction

    // Result, flags {N,Z,V,C} and start-to-writeback latency in edges.
    function automatic void model_alu(input int opc, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] res, output logic [3:0] fl, output int lat);
        int amt;
        bit v, c;
        longint s;
        logic signed [31:0] sa;
        amt = int'(b % 32);
        v = 0;
        c = 0;
        lat = 2;
        sa = a;
        case (opc)
            0: begin
                res = a + b;
                c = (longint'(a) + longint'(b)) > 64'h0000_0000_FFFF_FFFF;
                s = longint'($signed(a)) + longint'($signed(b));
                v = (s > longint'(32'sh7FFF_FFFF)) || (s < longint'(32'sh8000_0000));
            end
            1: begin
                res = a - b;
                c = (a < b);
                s = longint'($signed(a)) - longint'($signed(b));
                v = (s > longint'(32'sh7FFF_FFFF)) || (s < longint'(32'sh8000_0000));
            end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: res = a & ~b;
            7: res = b;
            8: begin
                res = a << amt;
                if (amt > 0) c = a[32 - amt];
                lat = 2 + amt;
            end
            9: begin
                res = a >> amt;
                if (amt > 0) c = a[amt - 1];
                lat = 2 + amt;
            end
            10: begin
                res = sa >>> amt;
                if (amt > 0) c = a[amt - 1];
                lat = 2 + amt;
            end
            default: res = a;
        endcase
        fl = {res[31], (res == 32'h0), v, c};
    endfunction

    // ------------------------------------------------------------ stimulus helpers
    task automatic idle_inputs();
        start = 0; op = 0; setcc = 0; wren = 0;
        sel_a = 1; sel_b = 1; sel_c = 1;
        ctl_a = 0; ctl_b = 0; ctl_c = 0;
        clr = 0; clrsel = 0;
        extwr = 0; extsel = 0; extdata = 0;
    endtask

    task automatic ext_write(input int idx, input logic [31:0] val);
        extwr = 1; extsel = 6'(idx); extdata = val;
        tick();
        extwr = 0;
        m_write(idx, val);
    endtask

    task automatic read_reg(input int idx, output logic [31:0] val);
        sel_a = 1; ctl_a = 6'(idx);
        #1;
        val = bus_a;
    endtask

    // junk: 0 none, 1 stray starts while busy, 2 stray starts and external writes.
    // b2b: leave the done cycle open so the next op starts in it.
    task automatic run_op(input int opc, input bit sa, input bit sb, input bit sc,
                          input int ca, input int cb, input int cc,
                          input bit sc_i, input bit wr_i, input int junk, input bit b2b);
        logic [31:0] irv, a, b, res, rb;
        logic [3:0]  fl;
        int ia, ib, ic, lat, cyc, eidx;
        irv = m_regs[IRI];
        ia = sa ? ca : int'(irv[18:14]);
        ib = sb ? cb : int'(irv[4:0]);
        ic = sc ? cc : int'(irv[29:25]);
        a = m_read(ia);
        b = m_read(ib);
        model_alu(opc, a, b, res, fl, lat);

        start = 1; op = 4'(opc); setcc = sc_i; wren = wr_i;
        sel_a = sa; sel_b = sb; sel_c = sc;
        ctl_a = 6'(ca); ctl_b = 6'(cb); ctl_c = 6'(cc);
        tick();
        start = 0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            if (junk > 0) begin
                start = 1'($urandom);
                op = 4'($urandom);
                ctl_a = 6'($urandom); ctl_b = 6'($urandom); ctl_c = 6'($urandom);
                if (junk > 1 && ($urandom % 3) == 0) begin
                    eidx = $urandom % 64;
                    if (eidx != ic) begin
                        extwr = 1; extsel = 6'(eidx); extdata = $urandom;
                    end
                end
            end
            tick();
            if (extwr) m_write(int'(extsel), extdata);
            start = 0; extwr = 0;
        end
        check_val("busy_cycles", 32'(cyc), 32'(lat - 1));
        check_val("done_pulse", 32'(done), 32'd1);
        check_val("data_out", data_out, res);
        m_data = res;
        if (sc_i) m_psr = fl;
        check_val("psr", 32'(psr), 32'(m_psr));
        if (wr_i) m_write(ic, res);
        $display("op=%0d A[%0d]=%08h B[%0d]=%08h C=%0d -> %08h psr=%b busy=%0d",
                 opc, ia, a, ib, b, ic, res, psr, cyc);
        read_reg(ic, rb);
        check_val("writeback", rb, m_read(ic));
        if (!b2b) begin
            idle_inputs();
            tick();
            check_val("done_low", 32'(done), 32'd0);
        end
    endtask

    // ------------------------------------------------------------ watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------ main
    initial begin
        logic [31:0] rv;
        int done_seen;
        bit chain;
        idle_inputs();
        m_reset();

        // Reset state
        #23 rst_n = 1;
        tick();
        sel_a = 0; sel_b = 0;
        #1;
        check_val("rst_bus_a", bus_a, 32'h0);
        check_val("rst_bus_b", bus_b, 32'h0);
        check_val("rst_ir", ir_out, 32'h0);
        check_val("rst_psr", 32'(psr), 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);
        check_val("rst_done", 32'(done), 32'h0);
        check_val("rst_data", data_out, 32'h0);
        idle_inputs();
        ext_write(0, 32'h1234);
        read_reg(0, rv);
        check_val("r0_hardwired", rv, 32'h0);

        // ADD overflow
        ext_write(1, 32'h7FFF_FFFF);
        ext_write(2, 32'h1);
        run_op(0, 1, 1, 1, 1, 2, 3, 1, 1, 0, 0);
        read_reg(3, rv);
        check_val("add_r3", rv, 32'h8000_0000);
        check_val("add_psr", 32'(psr), 32'b1010);

        // IR field selection
        ext_write(IRI, (32'd7 << 25) | (32'd5 << 14) | 32'd6);
        ext_write(5, 32'd10);
        ext_write(6, 32'd3);
        run_op(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        read_reg(7, rv);
        check_val("sub_r7", rv, 32'd7);
        check_val("sub_psr", 32'(psr), 32'b0000);

        // SRA with stray starts, then zero-amount SLL
        ext_write(4, 32'h8000_0001);
        ext_write(8, 32'd4);
        run_op(10, 1, 1, 1, 4, 8, 9, 1, 1, 1, 0);
        check_val("sra_data", data_out, 32'hF800_0000);
        check_val("sra_psr", 32'(psr), 32'b1000);
        run_op(8, 1, 1, 1, 4, 0, 10, 1, 1, 0, 0);
        check_val("sll0_data", data_out, 32'h8000_0001);
        check_val("sll0_c", 32'(psr[0]), 32'h0);

        // Clear beats writeback on the same edge
        start = 1; op = 0; wren = 1; setcc = 0;
        sel_a = 1; sel_b = 1; sel_c = 1; ctl_a = 1; ctl_b = 2; ctl_c = 3;
        tick();
        start = 0; clr = 1; clrsel = 3;
        tick();
        clr = 0;
        check_val("clr_done", 32'(done), 32'd1);
        check_val("clr_data", data_out, 32'h8000_0000);
        m_data = 32'h8000_0000;
        m_write(3, 32'h0);
        read_reg(3, rv);
        check_val("clr_wins", rv, 32'h0);
        idle_inputs();
        tick();

        // Writeback beats external write on the same edge
        start = 1; op = 0; wren = 1; setcc = 0;
        sel_a = 1; sel_b = 1; sel_c = 1; ctl_a = 1; ctl_b = 2; ctl_c = 3;
        tick();
        start = 0; extwr = 1; extsel = 3; extdata = 32'hDEAD_BEEF;
        tick();
        extwr = 0;
        m_write(3, 32'h8000_0000);
        read_reg(3, rv);
        check_val("wb_beats_ext", rv, 32'h8000_0000);
        idle_inputs();
        tick();

        // Randomized operations
        chain = 0;
        for (int t = 0; t < 60; t++) begin
            int nw, opc;
            bit b2b;
            if (!chain) begin
                nw = $urandom % 4;
                for (int k = 0; k < nw; k++) begin
                    if (($urandom % 4) == 0)
                        ext_write(IRI, $urandom);
                    else
                        ext_write($urandom % 64, (($urandom % 3) == 0) ? ($urandom % 40) : $urandom);
                end
            end
            opc = $urandom % 16;
            b2b = (($urandom % 4) == 0);
            run_op(opc, 1'($urandom), 1'($urandom), 1'($urandom),
                   $urandom % 64, $urandom % 64, $urandom % 64,
                   1'($urandom), 1'($urandom), 2, b2b);
            chain = b2b;
        end
        idle_inputs();
        tick();

        // Full register sweep on both buses
        for (int i = 0; i < 64; i++) begin
            sel_a = 1; sel_b = 1; ctl_a = 6'(i); ctl_b = 6'(63 - i);
            #1;
            check_val("sweep_a", bus_a, m_read(i));
            check_val("sweep_b", bus_b, m_read(63 - i));
        end
        idle_inputs();
        tick();

        // Reset in the middle of a shift
        ext_write(4, 32'h8000_0001);
        ext_write(11, 32'd12);
        start = 1; op = 9; setcc = 1; wren = 1;
        sel_a = 1; sel_b = 1; sel_c = 1; ctl_a = 4; ctl_b = 11; ctl_c = 12;
        tick();
        start = 0;
        tick();
        tick();
        check_val("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst_n = 0;
        #1;
        m_reset();
        check_val("midrst_busy", 32'(busy), 32'd0);
        check_val("midrst_done", 32'(done), 32'd0);
        check_val("midrst_data", data_out, 32'h0);
        check_val("midrst_psr", 32'(psr), 32'h0);
        @(posedge clk);
        #3 rst_n = 1;
        idle_inputs();
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done === 1'b1) done_seen++;
        end
        check_val("midrst_no_done", 32'(done_seen), 32'd0);
        check_val("midrst_idle", 32'(busy), 32'd0);
        read_reg(12, rv);
        check_val("midrst_no_wb", rv, 32'h0);
        read_reg(4, rv);
        check_val("midrst_r4_cleared", rv, m_read(4));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/udatapath_seq_gen.md
Name: udatapath_seq_gen

Overview:
- Parametrised, multi-cycle successor of the single-cycle microarchitecture datapath.
- Contains a generic register file with a hardwired zero register, an IR register that supplies rs1/rs2/rd fields, and per-bus index muxes choosing between the IR field and the control-unit value.
- The ALU executes under a start/busy/done handshake. Shifts are iterative, one bit per cycle. Writeback and PSR flag capture are registered.
- Sits between the control unit, which drives start/op/selects, and memory/IO, which loads registers through the external write port.

Parameters:
- DATAWIDTH_BUS, 32, data width of registers, buses and ALU.
- NUM_REGS, 40, number of register-file entries; index 0 is hardwired zero.
- REGSEL_WIDTH, 6, register index width; must satisfy 2**REGSEL_WIDTH >= NUM_REGS.
- IR_INDEX, 38, register-file index of the IR.
- ALU_SEL_WIDTH, 4, width of the operation code.

Ports:
- uDATAPATH_CLOCK_50  in  1  system clock, all logic on rising edge.
- uDATAPATH_RESET_InLow  in  1  asynchronous, active-low reset.
- uDATAPATH_start_InHigh  in  1  operation request; sampled only in IDLE.
- uDATAPATH_aluselection_InBUS  in  ALU_SEL_WIDTH  operation code.
- uDATAPATH_setcc_InHigh  in  1  update flags at writeback.
- uDATAPATH_wren_InHigh  in  1  write result to register C at writeback.
- uDATAPATH_BUS_SELECTOR_A/B/C  in  1 each  0 selects IR field, 1 selects control value.
- uDATAPATH_BUS_CONTROL_A/B/C  in  REGSEL_WIDTH each  control-unit register index.
- uDATAPATH_clear_InHigh  in  1  synchronous clear enable.
- uDATAPATH_clearsel_InBUS  in  REGSEL_WIDTH  register to clear.
- uDATAPATH_extwr_InHigh  in  1  external write enable.
- uDATAPATH_extsel_InBUS  in  REGSEL_WIDTH  external write index.
- uDATAPATH_extdata_InBUS  in  DATAWIDTH_BUS  external write data.
- uDATAPATH_BUS_A / uDATAPATH_BUS_B  out  DATAWIDTH_BUS  live combinational read of the selected registers.
- uDATAPATH_Registro_IR  out  DATAWIDTH_BUS  live IR contents.
- uDATAPATH_data_OutBUS  out  DATAWIDTH_BUS  registered last result.
- uDATAPATH_psr_OutBUS  out  4  registered flags {N,Z,V,C}, active high.
- uDATAPATH_busy_OutHigh  out  1  operation in progress.
- uDATAPATH_done_OutHigh  out  1  one-cycle pulse after writeback.

Behaviour:
- Reset (asynchronous, low): all registers 0, FSM to IDLE; busy, done, data_OutBUS and psr all 0. Reset mid-operation aborts with no writeback.
- Index muxes: field A = IR[18:14], field B = IR[4:0], field C = IR[29:25], each zero-extended to REGSEL_WIDTH. Each bus uses its field when its selector is 0, else its CONTROL value.
- Reads: index 0, or any index >= NUM_REGS, reads 0.
- Writes: writes to index 0 or to any index >= NUM_REGS are dropped.
- Operation codes: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 ANDN (A&~B), 6 PASS_A, 7 PASS_B, 8 SLL, 9 SRL, 10 SRA. Codes 11-15 behave as PASS_A.
- FSM states: IDLE, EXEC, SHIFT.
- IDLE, start=1: latch A, B, op, C index, setcc and wren; set busy=1.
  - Shift op with amount = B[log2(DATAWIDTH_BUS)-1:0] nonzero: go to SHIFT and load count=amount.
  - Otherwise: go to EXEC.
  - start is ignored outside IDLE.
- SHIFT: each edge shifts the working value by 1, captures the bit shifted out, and decrements count. When count reaches 1, go to EXEC.
- EXEC, one cycle: compute the result. On the next edge:
  - Write regfile[C] if wren was latched.
  - Load data_OutBUS.
  - Load psr if setcc was latched.
  - Go to IDLE with busy=0 and done=1 for exactly one cycle.
  - Start may be accepted in the same cycle that done=1.
- Latency: 2 edges from start sample to writeback for non-shift ops (start edge, then EXEC edge); 2+amount edges for shifts.
- Flags: N = result[MSB]; Z = (result == 0).
  - ADD/SUB: C = carry out for ADD, borrow for SUB; V = signed overflow.
  - Logical and PASS ops: V = 0, C = 0.
  - Shifts: C = last bit out (0 when amount is 0), V = 0.
- Write priority on the same edge to the same index: clear > writeback > external write. Writes to different indices all take effect.
- Operand latching: latched operands are unaffected by register or IR changes while busy. An external IR write while busy is permitted.

Test Plan:
- Reset: deassert reset; all reads 0, psr=0000, busy=0; ext write of 0x1234 to r0 -> BUS_A with CONTROL_A=0 reads 0.
- ADD timing: ext r1=0x7FFFFFFF, r2=1; start ADD with A=1, B=2, C=3, setcc, wren -> busy for 1 cycle, done 2 edges after start, r3=0x80000000, psr N=1 Z=0 V=1 C=0.
- IR-field select: ext IR with rs1=5, rs2=6, rd=7; r5=10, r6=3; SUB with all selectors 0 -> r7=7, psr=0000.
- Shifts and ignored start: r4=0x80000001, r8=4; SRA A=4, B=8 -> busy 5 cycles, result 0xF8000000, C=0; start during busy ignored. SLL with amount 0 -> result unchanged, latency 2, C=0.
- Write collision: clear and writeback to r3 on the same edge -> r3=0. Ext write and writeback to r3 -> writeback value wins.
- Reset mid-operation: reset asserted during SHIFT -> no writeback, busy=0, done never pulses.
